mole_game_core: RTL
===================

Name: mole_game_core

Overview:
Parametrised successor of the single-mole game loop. It supports N holes and several simultaneously active moles, each with its own lifetime timer, driven by a shared tick prescaler. It also keeps score, level, lives and win/lose state. The block sits between mouse_monitor/random_generator (inputs) and display_manager/buzzer_controller (outputs), replacing the inline loop in the top-level game logic.

Parameters:
NUM_HOLES, 12, number of mole holes (2..16)
MAX_ACTIVE, 4, cap on simultaneously active moles (1..NUM_HOLES)
MAX_LEVEL, 7, highest playable level; exceeding it is a win
INIT_LIVES, 5, lives at reset/restart (1..7)
LEVEL_STEP, 300, score per level threshold
TICK_SHIFT, 22, tick period = 2^TICK_SHIFT clk cycles
SCORE_W, 16, score width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
is_pause  in  1  freeze gameplay while high
mouse_click  in  1  left-click pulse (1 cycle)
mouse_right_click  in  1  right-click pulse (1 cycle)
mouse_click_mole  in  NUM_HOLES  per-hole hit mask for the current click
random_number  in  16  free-running pseudo-random value
state  out  2  0=IDLE 1=RUN 2=WIN 3=LOSE
is_start  out  1  state != IDLE
is_win  out  1  state == WIN
is_lose  out  1  state == LOSE
mole_up  out  NUM_HOLES  active-mole mask
score  out  SCORE_W  current score, saturating
level  out  4  current level, 1-based
live  out  3  remaining lives
hit_pulse  out  1  1-cycle pulse on a scored hit
miss_pulse  out  1  1-cycle pulse when at least one mole expires

Behaviour:
- Reset (async) values: state=IDLE, score=0, level=1, live=INIT_LIVES, mole_up=0, all hole timers=0, spawn cooldown=0, prescaler=0, pulses=0.
- FSM:
  - IDLE->RUN on mouse_click. The prescaler is cleared on entry.
  - RUN->LOSE when live==0.
  - RUN->WIN when level>MAX_LEVEL. LOSE has priority if both conditions hold in the same cycle.
  - WIN/LOSE->IDLE on mouse_right_click, reloading all reset values except state.
  - All transitions are registered and visible 1 cycle after the cause.
- Pause: in RUN with is_pause=1, the prescaler, timers, cooldown, spawns, hits and level are all frozen. Clicks are ignored and pulses stay 0. Resuming continues from the same counts.
- Tick:
  - The prescaler counts only in RUN & !is_pause.
  - tick=1 for one cycle when the prescaler equals 2^TICK_SHIFT-1, after which it wraps to 0.
- Per tick, in this order:
  - (a) Every nonzero hole timer decrements. A hole whose timer goes 1->0 clears its mole_up bit and counts as a miss.
  - (b) If cooldown==0 and popcount(mole_up after a) < max_active, spawn one mole. Otherwise, if cooldown>0, decrement cooldown.
- max_active = min(MAX_ACTIVE, 1+(level-1)/2).
- Spawn:
  - Start index s = random_number % NUM_HOLES.
  - Choose the first free hole at s, s+1, ... wrapping modulo NUM_HOLES.
  - Set its mole_up bit and timer = (random_number%200+100)/level ticks.
  - Set cooldown = (random_number%50+25)/level ticks.
  - All divisions are integer. Lifetimes are 9-bit; the minimum is 14, so never 0.
- Misses:
  - live decrements by the number of holes expiring on that tick, saturating at 0.
  - miss_pulse=1 that cycle.
- Hits (any RUN, unpaused cycle):
  - h = mouse_click_mole & mole_up. If h != 0, let j = lowest set index.
  - score += level * timer[j] (13-bit product; score saturates at 2^SCORE_W-1).
  - All holes in h are cleared and their timers zeroed. hit_pulse=1.
- Hit and expiry of the same hole on the same tick: the hit wins. Score uses timer before decrement, and no life is lost.
- Level up: evaluated on the registered score. If score >= LEVEL_STEP*level, level increments by 1 next cycle, at most one increment per cycle.
- mouse_click in RUN with h==0 has no effect.
- In WIN/LOSE, mole_up and timers hold. Only right-click acts.
- Reset asserted mid-game returns immediately to reset values.

Test Plan:
- Reset, then mouse_click -> state=1 next cycle; score=0, level=1, live=5, mole_up=0.
- TICK_SHIFT=2, random_number=5, RUN, level 1 -> on first tick mole_up=12'h020, timer[5]=105, cooldown=30.
- Level 3, mole_up=12'h800, random_number=11, cooldown 0 -> next spawn lands in hole 0; mole_up=12'h801 (max_active=2, so no third spawn).
- Level 2, timer[5]=40, click mask 12'h020 -> score +80, hit_pulse for 1 cycle, mole_up[5]=0. If score reaches 600, level=3 the following cycle.
- live=2, two holes at timer 1, tick -> live=0, miss_pulse=1, state=LOSE next cycle. Right-click -> IDLE, live=5, level=1, score=0.
- is_pause=1 for 1000 cycles with timer[3]=50 -> timer, cooldown and prescaler unchanged. A click during pause is ignored; counting resumes after is_pause falls.

Source files
------------

// File: rtl/mole_game_core.sv
// Whack-a-mole game core: N holes, several concurrent moles with per-hole lifetimes,
// shared tick prescaler, score/level/lives bookkeeping and IDLE/RUN/WIN/LOSE control.
module mole_game_core #(
    parameter int unsigned NUM_HOLES  = 12,
    parameter int unsigned MAX_ACTIVE = 4,
    parameter int unsigned MAX_LEVEL  = 7,
    parameter int unsigned INIT_LIVES = 5,
    parameter int unsigned LEVEL_STEP = 300,
    parameter int unsigned TICK_SHIFT = 22,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_pause,
    input  logic                 mouse_click,
    input  logic                 mouse_right_click,
    input  logic [NUM_HOLES-1:0] mouse_click_mole,
    input  logic [15:0]          random_number,
    output logic [1:0]           state,
    output logic                 is_start,
    output logic                 is_win,
    output logic                 is_lose,
    output logic [NUM_HOLES-1:0] mole_up,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           level,
    output logic [2:0]           live,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);
    localparam int unsigned TIMER_W = 9;
    localparam int unsigned COOL_W  = 7;
    localparam int unsigned PROD_W  = 13;
    localparam int unsigned HOLE_W  = $clog2(NUM_HOLES);
    localparam int unsigned CNT_W   = $clog2(NUM_HOLES + 1);
    localparam int unsigned SUM_W   = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_SHIFT-1:0] presc_q, presc_d;
    logic [TIMER_W-1:0]   timer_q [NUM_HOLES];
    logic [TIMER_W-1:0]   timer_d [NUM_HOLES];
    logic [COOL_W-1:0]    cool_q, cool_d;
    logic [NUM_HOLES-1:0] up_d, up_free, hit_mask, expire;
    logic [SCORE_W-1:0]   score_d;
    logic [3:0]           level_d;
    logic [2:0]           live_d;
    logic                 hit_d, miss_d, tick, found;
    logic [HOLE_W-1:0]    hit_idx, spawn_idx;
    logic [PROD_W-1:0]    prod;
    logic [SUM_W-1:0]     sum;
    logic [31:0]          act_lim, start_idx, cand;
    logic [CNT_W-1:0]     n_exp;
    logic [TIMER_W-1:0]   life;
    logic [COOL_W-1:0]    cool_new;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_HOLES-1:0] v);
        popcnt = '0;
        for (int i = 0; i < int'(NUM_HOLES); i++) popcnt = popcnt + CNT_W'(v[i]);
    endfunction

    assign state = state_q;

    // Game-state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; losing takes priority over winning
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (mouse_click) state_d = RUN;
            RUN: begin
                if (live == 3'd0)                 state_d = LOSE;
                else if (32'(level) > MAX_LEVEL)  state_d = WIN;
            end
            WIN, LOSE: if (mouse_right_click) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Gameplay datapath: hits, tick-driven expiry/spawn, lives and level
    always_comb begin
        presc_d   = presc_q;
        timer_d   = timer_q;
        cool_d    = cool_q;
        up_d      = mole_up;
        score_d   = score;
        level_d   = level;
        live_d    = live;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        tick      = 1'b0;
        found     = 1'b0;
        hit_mask  = '0;
        expire    = '0;
        up_free   = '0;
        hit_idx   = '0;
        spawn_idx = '0;
        prod      = '0;
        sum       = '0;
        act_lim   = '0;
        start_idx = '0;
        cand      = '0;
        n_exp     = '0;
        life      = TIMER_W'((32'(random_number) % 200 + 100) / 32'(level));
        cool_new  = COOL_W'((32'(random_number) % 50 + 25) / 32'(level));

        if (state_q == IDLE && mouse_click) begin
            presc_d = '0;
        end else if (state_q == RUN && !is_pause) begin
            tick    = &presc_q;
            presc_d = presc_q + TICK_SHIFT'(1);

            if (mouse_click) hit_mask = mouse_click_mole & mole_up;
            for (int i = int'(NUM_HOLES) - 1; i >= 0; i--)
                if (hit_mask[i]) hit_idx = HOLE_W'(i);
            if (hit_mask != '0) begin
                prod    = PROD_W'(level) * PROD_W'(timer_q[hit_idx]);
                sum     = SUM_W'(score) + SUM_W'(prod);
                score_d = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(sum);
                hit_d   = 1'b1;
            end

            // A hit on an expiring hole wins: it scores and costs no life
            for (int i = 0; i < int'(NUM_HOLES); i++) begin
                if (hit_mask[i]) begin
                    up_d[i]    = 1'b0;
                    timer_d[i] = '0;
                end else if (tick && timer_q[i] != '0) begin
                    timer_d[i] = timer_q[i] - TIMER_W'(1);
                    if (timer_q[i] == TIMER_W'(1)) begin
                        up_d[i]   = 1'b0;
                        expire[i] = 1'b1;
                    end
                end
            end

            if (tick) begin
                act_lim = (32'(level) - 1) / 2 + 1;
                if (act_lim > MAX_ACTIVE) act_lim = MAX_ACTIVE;
                up_free = up_d;
                if (cool_q == '0 && 32'(popcnt(up_free)) < act_lim) begin
                    start_idx = 32'(random_number) % NUM_HOLES;
                    for (int k = 0; k < int'(NUM_HOLES); k++) begin
                        cand = (start_idx + 32'(k)) % NUM_HOLES;
                        if (!found && !up_free[HOLE_W'(cand)]) begin
                            found     = 1'b1;
                            spawn_idx = HOLE_W'(cand);
                        end
                    end
                    if (found) begin
                        up_d[spawn_idx]    = 1'b1;
                        timer_d[spawn_idx] = life;
                        cool_d             = cool_new;
                    end
                end else if (cool_q != '0) begin
                    cool_d = cool_q - COOL_W'(1);
                end
            end

            n_exp  = popcnt(expire);
            miss_d = |expire;
            if (32'(live) > 32'(n_exp)) live_d = 3'(32'(live) - 32'(n_exp));
            else                        live_d = '0;

            if (32'(score) >= LEVEL_STEP * 32'(level) && 32'(level) <= MAX_LEVEL)
                level_d = level + 4'd1;
        end else if ((state_q == WIN || state_q == LOSE) && mouse_right_click) begin
            presc_d = '0;
            for (int i = 0; i < int'(NUM_HOLES); i++) timer_d[i] = '0;
            cool_d  = '0;
            up_d    = '0;
            score_d = '0;
            level_d = 4'd1;
            live_d  = 3'(INIT_LIVES);
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            for (int i = 0; i < int'(NUM_HOLES); i++) timer_q[i] <= '0;
            cool_q     <= '0;
            mole_up    <= '0;
            score      <= '0;
            level      <= 4'd1;
            live       <= 3'(INIT_LIVES);
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            is_start   <= 1'b0;
            is_win     <= 1'b0;
            is_lose    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            for (int i = 0; i < int'(NUM_HOLES); i++) timer_q[i] <= timer_d[i];
            cool_q     <= cool_d;
            mole_up    <= up_d;
            score      <= score_d;
            level      <= level_d;
            live       <= live_d;
            hit_pulse  <= hit_d;
            miss_pulse <= miss_d;
            is_start   <= (state_d != IDLE);
            is_win     <= (state_d == WIN);
            is_lose    <= (state_d == LOSE);
        end
    end

endmodule
